// File: rtl/vote_pkg.sv
// Shared definitions for the three-judge voting station front end:
// FSM state encoding, judge count, majority threshold and LED polarity.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    CLOSED = 2'd2
  } state_t;

  localparam int N_JUDGES = 3;
  localparam int MAJORITY = 2;

  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  // True when at least MAJORITY judges voted yes.
  function automatic logic is_majority(input logic [N_JUDGES-1:0] v);
    int yes_count;
    yes_count = 0;
    for (int i = 0; i < N_JUDGES; i++) begin
      yes_count += int'(v[i]);
    end
    return (yes_count >= MAJORITY);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one raw active-low board key: 2-flop synchronizer, stability
// counter that must see DB_CYCLES consecutive samples of a new level before
// accepting it, and a one-cycle pulse on each accepted press.
module key_debounce
  import vote_pkg::*;
#(
  parameter int DB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          sample_pressed;

  assign sample_pressed = ~sync2_q;
  assign press          = press_q;

  // Next-state: shift the synchronizer, count samples that disagree with the
  // accepted level, restart the count whenever the input falls back, and
  // accept the new level once the count completes.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sample_pressed == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sample_pressed;
      press_d = sample_pressed;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Registers; synchronizer resets to the released (high) key level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

endmodule

// File: rtl/vote_collector.sv
// Voting round controller: debounces the host and judge keys, latches one
// vote per judge per round, closes the round and drives the status LEDs.
// Optional macro VOTE_TIMEOUT_EN adds a WINDOW_CYCLES voting window timer
// whose expiry closes an open round; without it a round only closes on
// three votes or a host start press.
module vote_collector
  import vote_pkg::*;
#(
  parameter int DB_CYCLES     = 240000,
  parameter int WINDOW_CYCLES = 120000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_start_n,
  input  logic [N_JUDGES-1:0] key_vote_n,
  output logic [N_JUDGES-1:0] votes,
  output logic                votes_valid,
  output logic [N_JUDGES-1:0] num_led,
  output logic                result_led,
  output logic                busy_led
);

  logic                start_press;
  logic [N_JUDGES-1:0] vote_press;
  logic                timer_expired;

  state_t              state_q, state_d;
  logic [N_JUDGES-1:0] votes_q, votes_d;
  logic                votes_valid_q, votes_valid_d;
  logic [N_JUDGES-1:0] num_led_q, num_led_d;
  logic                result_led_q, result_led_d;
  logic                busy_led_q, busy_led_d;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_start_n),
    .press (start_press)
  );

  for (genvar j = 0; j < N_JUDGES; j++) begin : g_judge_db
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_vote_db (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_vote_n[j]),
      .press (vote_press[j])
    );
  end

`ifdef VOTE_TIMEOUT_EN
  localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  logic [TW-1:0] timer_q, timer_d;

  assign timer_expired = (timer_q == '0);

  // Window timer: reload whenever a round opens, then count down to zero
  // and stay there while the round remains open.
  always_comb begin
    timer_d = timer_q;
    if (state_d == OPEN && state_q != OPEN) begin
      timer_d = TIMER_LOAD;
    end else if (state_q == OPEN && timer_q != '0) begin
      timer_d = timer_q - TIMER_ONE;
    end
  end

  // Window timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timer_expired = 1'b0;
`endif

  // Round FSM and output next-state: votes pressed together with a closing
  // event are still counted because the close test uses the updated votes.
  always_comb begin
    state_d = state_q;
    votes_d = votes_q;
    case (state_q)
      IDLE: begin
        if (start_press) begin
          state_d = OPEN;
          votes_d = '0;
        end
      end
      OPEN: begin
        votes_d = votes_q | vote_press;
        if ((&votes_d) || start_press || timer_expired) begin
          state_d = CLOSED;
        end
      end
      CLOSED: begin
        if (start_press) begin
          state_d = OPEN;
          votes_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        votes_d = '0;
      end
    endcase

    votes_valid_d = (state_q == OPEN) && (state_d == CLOSED);
    num_led_d     = ~votes_d;
    result_led_d  = (state_d == CLOSED && is_majority(votes_d)) ? LED_ON : LED_OFF;
    busy_led_d    = (state_d == OPEN) ? LED_ON : LED_OFF;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      votes_q       <= '0;
      votes_valid_q <= 1'b0;
      num_led_q     <= {N_JUDGES{LED_OFF}};
      result_led_q  <= LED_OFF;
      busy_led_q    <= LED_OFF;
    end else begin
      state_q       <= state_d;
      votes_q       <= votes_d;
      votes_valid_q <= votes_valid_d;
      num_led_q     <= num_led_d;
      result_led_q  <= result_led_d;
      busy_led_q    <= busy_led_d;
    end
  end

  assign votes       = votes_q;
  assign votes_valid = votes_valid_q;
  assign num_led     = num_led_q;
  assign result_led  = result_led_q;
  assign busy_led    = busy_led_q;

endmodule

// File: doc/vote_collector.md
Name: vote_collector

Overview:
- Front end of the three-judge voting station. Takes raw judge and host keys from the board, debounces them, and runs a voting round. It latches each judge's vote once per round and closes the round.
- Outputs the latched vote vector with a valid strobe for the majority voter stage. Also drives the active-low vote-count, result and busy LEDs directly.

Parameters:
- DB_CYCLES, 240000, clock cycles a raw key must be stable before its level is accepted (20 ms at 12 MHz).
- WINDOW_CYCLES, 120000000, voting window length in clock cycles (10 s at 12 MHz); used only with VOTE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_start_n  in  1  host start/close key, raw, active-low
- key_vote_n  in  3  judge keys, raw, active-low; bit2=A, bit1=B, bit0=C
- votes  out  3  latched votes, 1=yes; bit order as key_vote_n
- votes_valid  out  1  one-cycle pulse when the round closes; votes stable while state=CLOSED
- num_led  out  3  ~votes (LED lit = 0)
- result_led  out  1  0 = motion passed; shown only in CLOSED, otherwise 1
- busy_led  out  1  0 while a round is OPEN

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high and forces every flop immediately.
- Reset values: state=IDLE, votes=000, votes_valid=0, num_led=111, result_led=1, busy_led=1, all debounce counters 0. Debounced key levels reset to released.
- Key input path: each key passes a 2-flop synchronizer, then a stability counter. The counter reloads on any change and accepts the new level after DB_CYCLES equal samples.
- Press pulse: one-cycle press pulse on accepted released->pressed transition only. Key release produces no event.
- Press latency: raw edge to press pulse = DB_CYCLES+2 cycles, ±1.
- FSM states: IDLE, OPEN, CLOSED.
- IDLE: start press -> OPEN. On entry, votes cleared to 000 and window timer loaded with WINDOW_CYCLES-1.
- OPEN, vote press: a judge press sets that judge's votes bit. The bit is one-shot per round; repeat presses are ignored and a vote cannot be withdrawn.
- OPEN, close conditions (any one closes the round):
  - all three bits set;
  - start press;
  - timer reaches 0 (VOTE_TIMEOUT_EN only).
- Close timing: votes pressed in the same cycle as a close condition are included in the round. The FSM enters CLOSED on the same edge.
- CLOSED: votes_valid=1 on the first cycle only. result_led = ~(popcount(votes) >= 2). Votes are held.
- CLOSED -> OPEN: a start press starts a new round (clear votes, reload timer). Judge presses in CLOSED are ignored.
- Simultaneous judge presses: all are latched in the same cycle.
- num_led: tracks votes in every state, so it shows live votes during OPEN.
- busy_led: 0 only in OPEN.
- Timer: counts down once per cycle in OPEN and saturates at 0. It has no effect in IDLE or CLOSED.
- Reset mid-round: returns to IDLE with votes=000. No votes_valid pulse is emitted.

Optional Feature:
- Macro: VOTE_TIMEOUT_EN.
- Defined: the window timer is instantiated, and expiry closes an OPEN round with whatever votes are latched.
- Undefined: there is no timer logic and WINDOW_CYCLES is unused. A round closes only on three votes or a start press, so OPEN may last indefinitely.

Decomposition:
- Shared package vote_pkg holds:
  - state encoding IDLE=2'd0, OPEN=2'd1, CLOSED=2'd2;
  - N_JUDGES=3;
  - MAJORITY=2;
  - LED_ON=1'b0, LED_OFF=1'b1.
- Sub-module key_debounce (parameter DB_CYCLES) contains synchronizer, stability counter, level output and press pulse. It is instantiated four times.

Test Plan (DB_CYCLES=4, WINDOW_CYCLES=100):
- Reset mid-OPEN with votes=100 -> on rst assertion: state IDLE, votes=000, num_led=111, busy_led=1, and no votes_valid pulse.
- Start press, then A, B, C presses 20 cycles apart -> votes 100->110->111. Close occurs on the C press edge with votes_valid one cycle, votes=111, result_led=0, num_led=000.
- Judge B key bouncing every 2 cycles for 30 cycles, then held -> exactly one vote latched (votes=010). No latch occurs before stable for DB_CYCLES.
- Start, press A only, press A again, then start -> votes=100 with the repeat ignored. Round closes on start with votes_valid, result_led=1.
- VOTE_TIMEOUT_EN defined: start, press A and C, idle 100 cycles -> CLOSED at timer 0, votes=101, result_led=0. Undefined: still OPEN after 1000 cycles.
- Last vote (A, after B and C) arriving the same cycle as timer expiry -> votes=111 included, single votes_valid pulse. A start press in CLOSED then gives votes=000, busy_led=0.
